// File: rtl/ultra_sensor_tx.sv
// Ultrasonic ranger front end: fires the trigger, times the synchronized echo pulse,
// and reports a 16-bit distance (16'hFFFF on timeout) with a one-cycle strobe.
module ultra_sensor_tx #(
  parameter int unsigned TRIG_CYC     = 1000,
  parameter int unsigned CYC_PER_UNIT = 5800,
  parameter int unsigned TIMEOUT_CYC  = 3_000_000,
  parameter int unsigned MAX_ECHO_CYC = 2_500_000,
  parameter int unsigned HOLDOFF_CYC  = 6_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        echo_ai,
  output logic        trig_o,
  output logic [15:0] data_o,
  output logic        data_av_o,
  output logic        timeout_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DIST_W = 16;
  localparam int unsigned PRE_W  = (CYC_PER_UNIT > 1) ? $clog2(CYC_PER_UNIT) : 1;

  localparam logic [DIST_W-1:0] DIST_SAT = 16'hFFFE;
  localparam logic [DIST_W-1:0] NO_ECHO  = 16'hFFFF;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TRIG    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_MEAS    = 3'd3;
  localparam logic [2:0] S_REPORT  = 3'd4;
  localparam logic [2:0] S_HOLDOFF = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic [1:0]        sync_q;
  logic              echo_dly_q;
  logic              trig_q, trig_d;
  logic [DIST_W-1:0] data_q, data_d;
  logic              av_q, av_d;
  logic              to_q, to_d;
  logic              busy_q, busy_d;

  logic echo_s_c;
  logic echo_rise_c;
  logic echo_fall_c;

  // Edges are taken between echo_s and its delayed copy; MEASURE counts the delayed
  // copy so the rising cycle itself is included and the falling cycle is not.
  assign echo_s_c    = sync_q[1];
  assign echo_rise_c = echo_s_c & ~echo_dly_q;
  assign echo_fall_c = ~echo_s_c & echo_dly_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    dist_d  = dist_q;
    data_d  = data_q;
    av_d    = 1'b0;
    to_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en_i) state_d = S_TRIG;
      end
      S_TRIG: begin
        if (cnt_q == CNT_W'(TRIG_CYC - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (echo_rise_c) begin
          state_d = S_MEAS;
          cnt_d   = '0;
          pre_d   = '0;
          dist_d  = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_REPORT;
          data_d  = NO_ECHO;
          av_d    = 1'b1;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_MEAS: begin
        if (echo_dly_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (pre_q == PRE_W'(CYC_PER_UNIT - 1)) begin
            pre_d = '0;
            if (dist_q != DIST_SAT) dist_d = dist_q + DIST_W'(1);
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        if (echo_dly_q && (cnt_q == CNT_W'(MAX_ECHO_CYC - 1))) begin
          state_d = S_REPORT;
          data_d  = NO_ECHO;
          av_d    = 1'b1;
          to_d    = 1'b1;
        end else if (echo_fall_c) begin
          state_d = S_REPORT;
          data_d  = dist_d;
          av_d    = 1'b1;
        end
      end
      S_REPORT: begin
        state_d = S_HOLDOFF;
        cnt_d   = '0;
      end
      S_HOLDOFF: begin
        if (cnt_q == CNT_W'(HOLDOFF_CYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    trig_d = (state_d == S_TRIG);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pre_q      <= '0;
      dist_q     <= '0;
      sync_q     <= '0;
      echo_dly_q <= 1'b0;
      trig_q     <= 1'b0;
      data_q     <= '0;
      av_q       <= 1'b0;
      to_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      dist_q     <= dist_d;
      sync_q     <= {sync_q[0], echo_ai};
      echo_dly_q <= echo_s_c;
      trig_q     <= trig_d;
      data_q     <= data_d;
      av_q       <= av_d;
      to_q       <= to_d;
      busy_q     <= busy_d;
    end
  end

  assign trig_o    = trig_q;
  assign data_o    = data_q;
  assign data_av_o = av_q;
  assign timeout_o = to_q;
  assign busy_o    = busy_q;

endmodule

// File: doc/ultra_sensor_tx.md
# ultra_sensor_tx

Sensor-side front end that produces the range samples the averaging path consumes. It drives an ultrasonic ranger's trigger pin and times the asynchronous echo pulse. It then converts the pulse width into a 16-bit distance and presents it on `data_o` with a one-cycle `data_av_o` strobe. That strobe is the producer end of the `data_i`/`data_av_ai` link into `ultra_top`.

## Interface
- `TRIG_CYC`, 1000: trigger pulse width in clk cycles (10 µs @ 100 MHz).
- `CYC_PER_UNIT`, 5800: echo-high cycles per distance unit (1 cm @ 100 MHz).
- `TIMEOUT_CYC`, 3_000_000: max cycles from trigger end to echo rise.
- `MAX_ECHO_CYC`, 2_500_000: max echo-high cycles before forced timeout.
- `HOLDOFF_CYC`, 6_000_000: idle gap after each report (60 ms), lets sensor ring down.
- `clk`, in, 1: single clock; all logic rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `en_i`, in, 1: continuous-ranging enable, sampled in IDLE only.
- `echo_ai`, in, 1: asynchronous echo from sensor.
- `trig_o`, out, 1: trigger to sensor, registered.
- `data_o`, out, 16: distance in units; 16'hFFFF = no valid echo.
- `data_av_o`, out, 1: one-cycle strobe; `data_o` valid in the same cycle and held until the next strobe.
- `timeout_o`, out, 1: one-cycle strobe coincident with `data_av_o` when the sample is a timeout.
- `busy_o`, out, 1: high in every state except IDLE.

## Operation
- `echo_ai` passes through a 2-flop synchronizer into `echo_s`. An edge detector on `echo_s` generates `echo_rise` and `echo_fall`. No logic uses the raw input.
- FSM states:
  - IDLE: `en_i`=1 -> TRIG, and the cycle counter clears.
  - TRIG: `trig_o`=1 for exactly `TRIG_CYC` cycles, then -> WAIT_ECHO with the counter cleared.
  - WAIT_ECHO: `echo_rise` -> MEASURE, with the prescaler and distance cleared. If the counter reaches `TIMEOUT_CYC`-1 -> REPORT with the timeout flag set.
  - MEASURE: each cycle with `echo_s`=1 increments the prescaler (0..`CYC_PER_UNIT`-1). On prescaler wrap, distance increments, saturating at 16'hFFFE. `echo_fall` -> REPORT. If the echo-high count reaches `MAX_ECHO_CYC` -> REPORT with the timeout flag set.
  - REPORT: one cycle. `data_o` <= timeout ? 16'hFFFF : distance. `data_av_o`=1, `timeout_o`=timeout. Then -> HOLDOFF.
  - HOLDOFF: `HOLDOFF_CYC` cycles, then -> IDLE.
- Result: distance = floor(N / `CYC_PER_UNIT`), where N is the number of synchronized echo-high cycles. A valid measurement never yields 16'hFFFF.
- Echo activity during IDLE, TRIG or HOLDOFF is ignored. An echo already high when WAIT_ECHO is entered is not a rise; the block waits for a fresh rising edge.
- `en_i` deasserted outside IDLE: the current measurement completes and reports, then the block stays in IDLE.
- Reset mid-operation: next cycle the state is IDLE and all outputs are at reset values. No strobe is emitted for an aborted measurement.

## Timing
- Reset values: `trig_o`=0, `data_o`=16'h0000, `data_av_o`=0, `timeout_o`=0, `busy_o`=0. The synchronizer and counters are cleared.
- `trig_o` rises the cycle after IDLE samples `en_i`=1 and stays high for exactly `TRIG_CYC` cycles.
- Echo path latency: 2 cycles through the synchronizer plus 1 cycle for edge detect.
- `data_av_o` asserts exactly 1 cycle after `echo_fall` is detected.
  - On timeout, it asserts 1 cycle after the counter limit is reached.
- Trigger period with `en_i` held high: `TRIG_CYC` + measure time + 1 + `HOLDOFF_CYC` + 1 (IDLE) cycles.
- `data_av_o` is never high in two consecutive cycles. Every strobe is separated by at least `HOLDOFF_CYC`+`TRIG_CYC` cycles, so the receiver's asynchronous strobe capture always sees clean single pulses.

## Test plan
Simulation parameters: `TRIG_CYC`=10, `CYC_PER_UNIT`=5, `TIMEOUT_CYC`=100, `MAX_ECHO_CYC`=400, `HOLDOFF_CYC`=20.

- Normal echo: `en_i`=1, echo high 50 cycles, starting 30 cycles after trigger -> `trig_o` high exactly 10 cycles. One `data_av_o` pulse with `data_o`=10, `timeout_o`=0, then `busy_o` falls after the 20-cycle holdoff.
- Short echo: echo high 4 cycles -> `data_o`=0 with one strobe. Echo high 14 cycles -> `data_o`=2.
- No echo: `echo_ai` held 0 -> a strobe 100 cycles after the trigger ends, with `data_o`=16'hFFFF and `timeout_o`=1 in the same cycle.
- Stuck echo: echo rises and stays high 500 cycles -> timeout report at echo-high count 400, with `data_o`=16'hFFFF and `timeout_o`=1.
- Reset and glitches:
  - Echo pulses during TRIG and HOLDOFF -> no extra strobes; the result is taken from the WAIT_ECHO echo only.
  - `rst` asserted mid-MEASURE -> all outputs 0 the next cycle and no strobe. A fresh trigger follows when `rst` drops with `en_i`=1.
- Continuous ranging: `en_i` held 1 with echoes of 25, 40 and 60 cycles -> three strobes with `data_o`=5, 8, 12. Gaps between strobes are at least 30 cycles.
